// File: rtl/computedram_sequencer.sv
// computedram_sequencer
// Accepts a two-row ComputeDRAM request, takes the DRAM command bus from the
// controller and issues PREA, ACT(R1), PRE, ACT(R2), PRE with programmable
// gaps, then closes the bank and hands the bus back.
// Every output is a flop decoded from the current state, so pins trail the
// state register by one cycle.

module computedram_sequencer #(
    parameter int ADDR_W = 15,
    parameter int BANK_W = 3,
    parameter int BANK   = 0,
    parameter int TRP    = 4,
    parameter int TRAS   = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [9:0]        ComputeDRAM_R1,
    input  logic [9:0]        ComputeDRAM_R2,
    input  logic [3:0]        ComputeDRAM_T1,
    input  logic [3:0]        ComputeDRAM_T2,
    input  logic              ComputeDRAM_vld,
    output logic              ComputeDRAM_rdy,
    output logic              ComputeDRAM_done,
    output logic              ctrl_req,
    input  logic              ctrl_gnt,
    output logic              dfi_cs_n,
    output logic              dfi_ras_n,
    output logic              dfi_cas_n,
    output logic              dfi_we_n,
    output logic [ADDR_W-1:0] dfi_address,
    output logic [BANK_W-1:0] dfi_bank
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_PREA, S_W0, S_ACT1, S_W1, S_PRE1,
        S_W2, S_ACT2, S_W3, S_PRE2, S_W4, S_REL
    } state_t;

    // Wait states count down to zero, so they are loaded with gap-1.
    localparam logic [7:0] TRP_M1  = 8'(TRP - 1);
    localparam logic [7:0] TRAS_M1 = 8'(TRAS - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [9:0]          r1_q, r1_d, r2_q, r2_d;
    logic [3:0]          t1_q, t1_d, t2_q, t2_d;
    logic                rdy_q, rdy_d;
    logic                done_q, done_d;
    logic                ctrl_req_q, ctrl_req_d;
    logic                ras_n_q, ras_n_d;
    logic                we_n_q, we_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic                accept;

    assign accept = (state_q == S_IDLE) && ComputeDRAM_vld && rdy_q;

    // Next-state, gap counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ;
                    r1_d    = ComputeDRAM_R1;
                    r2_d    = ComputeDRAM_R2;
                    t1_d    = ComputeDRAM_T1;
                    t2_d    = ComputeDRAM_T2;
                end
            end
            S_REQ:  if (ctrl_gnt) state_d = S_PREA;
            S_PREA: begin
                state_d = S_W0;
                cnt_d   = TRP_M1;
            end
            S_W0: begin
                if (cnt_q == 8'd0) state_d = S_ACT1;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_ACT1: begin
                if (t1_q == 4'd0) begin
                    state_d = S_PRE1;
                end else begin
                    state_d = S_W1;
                    cnt_d   = {4'd0, t1_q} - 8'd1;
                end
            end
            S_W1: begin
                if (cnt_q == 8'd0) state_d = S_PRE1;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_PRE1: begin
                if (t2_q == 4'd0) begin
                    state_d = S_ACT2;
                end else begin
                    state_d = S_W2;
                    cnt_d   = {4'd0, t2_q} - 8'd1;
                end
            end
            S_W2: begin
                if (cnt_q == 8'd0) state_d = S_ACT2;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_ACT2: begin
                state_d = S_W3;
                cnt_d   = TRAS_M1;
            end
            S_W3: begin
                if (cnt_q == 8'd0) state_d = S_PRE2;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_PRE2: begin
                state_d = S_W4;
                cnt_d   = TRP_M1;
            end
            S_W4: begin
                if (cnt_q == 8'd0) state_d = S_REL;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_REL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin decode from the current state; anything that is not a command is a NOP.
    always_comb begin
        rdy_d      = (state_q == S_IDLE) && !accept;
        done_d     = (state_q == S_REL);
        ctrl_req_d = !((state_q == S_IDLE) || (state_q == S_REL));
        ras_n_d    = 1'b1;
        we_n_d     = 1'b1;
        addr_d     = '0;
        bank_d     = '0;
        case (state_q)
            S_PREA: begin
                ras_n_d    = 1'b0;
                we_n_d     = 1'b0;
                addr_d[10] = 1'b1;
                bank_d     = BANK_W'(BANK);
            end
            S_ACT1: begin
                ras_n_d = 1'b0;
                addr_d  = ADDR_W'(r1_q);
                bank_d  = BANK_W'(BANK);
            end
            S_ACT2: begin
                ras_n_d = 1'b0;
                addr_d  = ADDR_W'(r2_q);
                bank_d  = BANK_W'(BANK);
            end
            S_PRE1, S_PRE2: begin
                ras_n_d = 1'b0;
                we_n_d  = 1'b0;
                bank_d  = BANK_W'(BANK);
            end
            default: ;
        endcase
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            ctrl_req_q <= 1'b0;
            ras_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            addr_q     <= '0;
            bank_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            ctrl_req_q <= ctrl_req_d;
            ras_n_q    <= ras_n_d;
            we_n_q     <= we_n_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
        end
    end

    assign ComputeDRAM_rdy  = rdy_q;
    assign ComputeDRAM_done = done_q;
    assign ctrl_req         = ctrl_req_q;
    assign dfi_cs_n         = 1'b0;
    assign dfi_ras_n        = ras_n_q;
    assign dfi_cas_n        = 1'b1;
    assign dfi_we_n         = we_n_q;
    assign dfi_address      = addr_q;
    assign dfi_bank         = bank_q;

endmodule

// File: tb/tb_computedram_sequencer.sv
// Bench for computedram_sequencer: the driver predicts the cycle of every
// observable event of a request and queues it; the monitor pops and compares
// as the events appear on the pins.

module tb_computedram_sequencer;

    localparam int ADDR_W = 15;
    localparam int BANK_W = 3;
    localparam int BANK   = 3;
    localparam int TRP    = 4;
    localparam int TRAS   = 10;

    localparam int EV_REQ  = 0;
    localparam int EV_ACT  = 1;
    localparam int EV_PRE  = 2;
    localparam int EV_DONE = 3;
    localparam int EV_RDY  = 4;

    typedef struct {
        int kind;
        int cyc;
        int addr;
        int bank;
    } ev_t;

    logic              sys_clk;
    logic              sys_rst;
    logic [9:0]        r1_in, r2_in;
    logic [3:0]        t1_in, t2_in;
    logic              vld;
    logic              rdy;
    logic              done;
    logic              ctrl_req;
    logic              ctrl_gnt;
    logic              cs_n, ras_n, cas_n, we_n;
    logic [ADDR_W-1:0] address;
    logic [BANK_W-1:0] bank;

    int  assert_cnt = 0;
    int  fail_cnt   = 0;
    int  cyc        = 0;
    bit  prev_req   = 0;
    bit  prev_rdy   = 0;
    ev_t exp_q[$];

    computedram_sequencer #(
        .ADDR_W(ADDR_W), .BANK_W(BANK_W), .BANK(BANK), .TRP(TRP), .TRAS(TRAS)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .ComputeDRAM_R1  (r1_in),
        .ComputeDRAM_R2  (r2_in),
        .ComputeDRAM_T1  (t1_in),
        .ComputeDRAM_T2  (t2_in),
        .ComputeDRAM_vld (vld),
        .ComputeDRAM_rdy (rdy),
        .ComputeDRAM_done(done),
        .ctrl_req        (ctrl_req),
        .ctrl_gnt        (ctrl_gnt),
        .dfi_cs_n        (cs_n),
        .dfi_ras_n       (ras_n),
        .dfi_cas_n       (cas_n),
        .dfi_we_n        (we_n),
        .dfi_address     (address),
        .dfi_bank        (bank)
    );

    // 10 ns clock.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edge counter; read at negedges it names the cycle currently on the pins.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_cnt++;
        if (actual != expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushEv(input int kind, input int c, input int addr, input int bnk);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = addr;
        e.bank = bnk;
        exp_q.push_back(e);
    endtask

    task automatic handleEvent(input int kind, input int addr, input int bnk);
        ev_t e;
        if (exp_q.size() == 0) begin
            assert_cnt++;
            fail_cnt++;
            $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput($sformatf("event_cycle_k%0d", e.kind), cyc, e.cyc);
            if (e.kind == EV_ACT || e.kind == EV_PRE) begin
                checkOutput("cmd_address", addr, e.addr);
                checkOutput("cmd_bank", bnk, e.bank);
            end
        end
    endtask

    // Monitor: reset values while in reset, otherwise turn pin activity into events.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            checkOutput("rst_rdy", int'(rdy), 0);
            checkOutput("rst_done", int'(done), 0);
            checkOutput("rst_ctrl_req", int'(ctrl_req), 0);
            checkOutput("rst_cs_n", int'(cs_n), 0);
            checkOutput("rst_ras_n", int'(ras_n), 1);
            checkOutput("rst_cas_n", int'(cas_n), 1);
            checkOutput("rst_we_n", int'(we_n), 1);
            checkOutput("rst_address", int'(address), 0);
            checkOutput("rst_bank", int'(bank), 0);
        end else begin
            checkOutput("cs_n_low", int'(cs_n), 0);
            checkOutput("cas_n_high", int'(cas_n), 1);
            if (ctrl_req && !prev_req) handleEvent(EV_REQ, 0, 0);
            if (!ras_n) handleEvent(we_n ? EV_ACT : EV_PRE, int'(address), int'(bank));
            else checkOutput("nop_we_n", int'(we_n), 1);
            if (done) handleEvent(EV_DONE, 0, 0);
            if (rdy && !prev_rdy) handleEvent(EV_RDY, 0, 0);
            if (rdy) checkOutput("req_low_when_ready", int'(ctrl_req), 0);
        end
        prev_req = ctrl_req;
        prev_rdy = rdy;
    end

    // Issue one request and predict its full event trace from the gap rules.
    // gdly holds the grant low for that many cycles of REQ; scramble keeps vld
    // high with changing inputs while busy; mid_reset hits reset during W1.
    task automatic applyStimulus(input logic [9:0] r1, input logic [9:0] r2,
                                 input logic [3:0] t1, input logic [3:0] t2,
                                 input int gdly, input bit scramble, input bit mid_reset);
        int k, g, p, a1, pr1, a2, pr2, dn, waited;
        @(negedge sys_clk);
        r1_in = r1; r2_in = r2; t1_in = t1; t2_in = t2;
        vld = 1'b1;
        ctrl_gnt = (gdly == 0);
        waited = 0;
        while (!rdy) begin
            waited++;
            if (waited > 300) begin
                checkOutput("rdy_timeout", 0, 1);
                vld = 1'b0;
                return;
            end
            @(negedge sys_clk);
        end
        k   = cyc + 1;
        g   = k + 1 + gdly;
        p   = g + 1;
        a1  = p + 1 + TRP;
        pr1 = a1 + 1 + int'(t1);
        a2  = pr1 + 1 + int'(t2);
        pr2 = a2 + 1 + TRAS;
        dn  = pr2 + 1 + TRP;
        pushEv(EV_REQ, k + 1, 0, 0);
        pushEv(EV_PRE, p, 1024, BANK);
        pushEv(EV_ACT, a1, int'(r1), BANK);
        if (!mid_reset) begin
            pushEv(EV_PRE, pr1, 0, BANK);
            pushEv(EV_ACT, a2, int'(r2), BANK);
            pushEv(EV_PRE, pr2, 0, BANK);
            pushEv(EV_DONE, dn, 0, 0);
            pushEv(EV_RDY, dn + 1, 0, 0);
        end
        do begin
            @(negedge sys_clk);
            if (!scramble || cyc >= dn) vld = 1'b0;
            if (scramble) begin
                r1_in = 10'($urandom_range(0, 1023));
                r2_in = 10'($urandom_range(0, 1023));
                t1_in = 4'($urandom_range(0, 15));
                t2_in = 4'($urandom_range(0, 15));
            end
            if (gdly > 0 && cyc >= k + 1 && cyc <= k + gdly) begin
                checkOutput("req_held_waiting_gnt", int'(ctrl_req), 1);
                checkOutput("nop_waiting_gnt", int'(ras_n), 1);
            end
            if (gdly > 0 && cyc == k + gdly) ctrl_gnt = 1'b1;
            if (mid_reset && cyc == a1 + 2) begin
                vld = 1'b0;
                #2 sys_rst = 1'b1;
                #1;
                checkOutput("async_req_drop", int'(ctrl_req), 0);
                checkOutput("async_nop", int'(ras_n), 1);
                repeat (3) @(negedge sys_clk);
                #2 sys_rst = 1'b0;
                pushEv(EV_RDY, cyc + 1, 0, 0);
                return;
            end
        end while (cyc < dn);
    endtask

    // Watchdog so a stuck design still produces a summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        fail_cnt++;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    // Test sequence: reset, directed cases, then random requests.
    initial begin
        sys_rst  = 1'b1;
        vld      = 1'b0;
        ctrl_gnt = 1'b1;
        r1_in = '0; r2_in = '0; t1_in = '0; t2_in = '0;
        repeat (3) @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        pushEv(EV_RDY, cyc + 1, 0, 0);
        $display("[TB] reset released");

        applyStimulus(10'd4, 10'd5, 4'd2, 4'd2, 0, 1'b0, 1'b0);
        applyStimulus(10'd17, 10'd900, 4'd0, 4'd0, 0, 1'b0, 1'b0);
        applyStimulus(10'd321, 10'd123, 4'd1, 4'd3, 20, 1'b0, 1'b0);
        applyStimulus(10'd1023, 10'd0, 4'd7, 4'd15, 0, 1'b1, 1'b0);
        applyStimulus(10'd55, 10'd66, 4'd8, 4'd2, 0, 1'b0, 1'b1);
        applyStimulus(10'd600, 10'd601, 4'd3, 4'd0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge sys_clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
